uart_multi_regs: RTL and testbench

Parametrised register file for an N-channel UART subsystem, sitting between the host bus slave and the per-channel UART transmit/receive cores. Each channel has a control register, status and receive-data passthroughs, a transmit data register, an interrupt enable register and a sticky write-1-to-clear interrupt status register. Reads are registered with a valid strobe. Per-channel access strobes and interrupt outputs are driven to the channel cores and the interrupt controller.

---
 rtl/uart_regs_pkg.sv | 34 +++
 rtl/uart_ch_regs.sv | 107 ++++++++++
 rtl/uart_multi_regs.sv | 151 +++++++++++++++
 tb/tb_uart_multi_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regs_pkg.sv
// ----------------------------------------------------------------------------
// uart_regs_pkg
//
// Shared definitions for the multi-channel UART register file:
//   - word offsets of the per-channel registers inside an 8-word channel window
//   - reset value of the control register and the value returned for reads of
//     addresses that map to nothing
//   - bit positions of the self-clearing receiver/transmitter reset bits in CR
//   - derivation of the word address width from the channel count
// ----------------------------------------------------------------------------
package uart_regs_pkg;

   // Register offsets within a channel window (addr[2:0])
   localparam logic [2:0] OFF_CR  = 3'd0;
   localparam logic [2:0] OFF_SR  = 3'd1;
   localparam logic [2:0] OFF_TDR = 3'd2;
   localparam logic [2:0] OFF_RDR = 3'd3;
   localparam logic [2:0] OFF_IER = 3'd4;
   localparam logic [2:0] OFF_ISR = 3'd5;

   // Reset value of every channel's CR and the value read from unmapped space
   localparam logic [31:0] CR_RESET_VAL = 32'h0000_C000;
   localparam logic [31:0] READ_DEFAULT = 32'hFFFF_0000;

   // CR bits that drop back to 0 one cycle after being written as 1
   localparam int CR_RX_RESET = 1;
   localparam int CR_TX_RESET = 2;

   // Three offset bits plus enough bits to select any channel
   function automatic int calc_addr_w(input int num_ch);
      return $clog2(num_ch) + 3;
   endfunction

endpackage

// File: rtl/uart_ch_regs.sv
// ----------------------------------------------------------------------------
// uart_ch_regs
//
// Register state for a single UART channel: control (CR), transmit data (TDR),
// interrupt enable (IER) and sticky write-1-to-clear interrupt status (ISR),
// plus the registered interrupt output of the channel.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cr_we            write strobe for CR (already decoded by the top level)
//   tdr_we           write strobe for TDR
//   ier_we           write strobe for IER
//   isr_we           write strobe for ISR (W1C)
//   write_data       host write data
//   irq_evt          interrupt event pulses from the channel cores
//   cr, tdr          current CR / TDR contents
//   ier, isr         current IER / ISR contents, zero-extended to DATA_W
//   irq              registered |(ISR & IER)
// ----------------------------------------------------------------------------
module uart_ch_regs
   import uart_regs_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IRQ_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cr_we,
   input  logic              tdr_we,
   input  logic              ier_we,
   input  logic              isr_we,
   input  logic [DATA_W-1:0] write_data,
   input  logic [IRQ_W-1:0]  irq_evt,
   output logic [DATA_W-1:0] cr,
   output logic [DATA_W-1:0] tdr,
   output logic [DATA_W-1:0] ier,
   output logic [DATA_W-1:0] isr,
   output logic              irq
);

   localparam logic [DATA_W-1:0] SELF_CLEAR_MASK =
      (DATA_W'(1) << CR_RX_RESET) | (DATA_W'(1) << CR_TX_RESET);

   logic [DATA_W-1:0] cr_q,  cr_d;
   logic [DATA_W-1:0] tdr_q, tdr_d;
   logic [IRQ_W-1:0]  ier_q, ier_d;
   logic [IRQ_W-1:0]  isr_q, isr_d;
   logic              irq_q, irq_d;

   // Next-state logic for the channel registers.
   // The CR reset bits are cleared unconditionally every cycle: any reset bit
   // that is 1 now was written in the previous cycle, so it has had its one
   // cycle of visibility. A CR write replaces the whole register afterwards,
   // which lets a write landing in the clear cycle take precedence.
   // ISR applies the W1C mask first and ORs in new events last so that an
   // event arriving together with a clear of the same bit keeps it set.
   // irq is computed from the next-state ISR/IER so that an event in cycle T
   // raises irq in T+1 rather than T+2.
   always_comb begin
      cr_d = cr_q & ~SELF_CLEAR_MASK;
      if (cr_we) begin
         cr_d = write_data;
      end

      tdr_d = tdr_q;
      if (tdr_we) begin
         tdr_d = write_data;
      end

      ier_d = ier_q;
      if (ier_we) begin
         ier_d = write_data[IRQ_W-1:0];
      end

      isr_d = isr_q;
      if (isr_we) begin
         isr_d = isr_q & ~write_data[IRQ_W-1:0];
      end
      isr_d = isr_d | irq_evt;

      irq_d = |(isr_d & ier_d);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cr_q  <= DATA_W'(CR_RESET_VAL);
         tdr_q <= '0;
         ier_q <= '0;
         isr_q <= '0;
         irq_q <= 1'b0;
      end else begin
         cr_q  <= cr_d;
         tdr_q <= tdr_d;
         ier_q <= ier_d;
         isr_q <= isr_d;
         irq_q <= irq_d;
      end
   end

   assign cr  = cr_q;
   assign tdr = tdr_q;
   assign ier = DATA_W'(ier_q);
   assign isr = DATA_W'(isr_q);
   assign irq = irq_q;

endmodule

// File: rtl/uart_multi_regs.sv
// ----------------------------------------------------------------------------
// uart_multi_regs
//
// Register file for an N-channel UART subsystem. Decodes the host word
// address into channel + register offset, fans out write/access strobes to
// one uart_ch_regs instance per channel and to the channel cores, and
// returns registered read data with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   addr         word address: addr[2:0] offset, upper bits channel index
//   we, re       single-cycle write / read strobes (may coincide)
//   write_data   host write data
//   read_data    registered read data, held until the next read
//   rvalid       one cycle after re
//   sr, rdr      live per-channel status / receive data from the cores
//   irq_evt      per-channel interrupt event pulses
//   cr, tdr      per-channel control / transmit data registers
//   tx_write     per-channel TDR write strobe
//   rx_read      per-channel RDR read strobe
//   sr_read      per-channel SR read strobe
//   irq          per-channel registered interrupt
// ----------------------------------------------------------------------------
module uart_multi_regs
   import uart_regs_pkg::*;
#(
   parameter  int NUM_CH = 2,
   parameter  int DATA_W = 32,
   parameter  int IRQ_W  = 8,
   localparam int ADDR_W = calc_addr_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     we,
   input  logic                     re,
   input  logic [DATA_W-1:0]        write_data,
   output logic [DATA_W-1:0]        read_data,
   output logic                     rvalid,
   input  logic [NUM_CH*DATA_W-1:0] sr,
   input  logic [NUM_CH*DATA_W-1:0] rdr,
   input  logic [NUM_CH*IRQ_W-1:0]  irq_evt,
   output logic [NUM_CH*DATA_W-1:0] cr,
   output logic [NUM_CH*DATA_W-1:0] tdr,
   output logic [NUM_CH-1:0]        tx_write,
   output logic [NUM_CH-1:0]        rx_read,
   output logic [NUM_CH-1:0]        sr_read,
   output logic [NUM_CH-1:0]        irq
);

   logic [ADDR_W-1:0] ch_field;
   logic [2:0]        offset;
   logic              ch_valid;
   logic              off_valid;
   logic [NUM_CH-1:0] ch_hit;
   logic [NUM_CH-1:0] cr_we;
   logic [NUM_CH-1:0] ier_we;
   logic [NUM_CH-1:0] isr_we;
   logic [DATA_W-1:0] ier_all [NUM_CH];
   logic [DATA_W-1:0] isr_all [NUM_CH];

   logic [DATA_W-1:0] rd_mux;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              rvalid_q, rvalid_d;

   // The channel field is kept at full address width so that indices beyond
   // NUM_CH (possible when NUM_CH is not a power of two) can be rejected.
   assign ch_field  = addr >> 3;
   assign offset    = addr[2:0];
   assign ch_valid  = (ch_field < ADDR_W'(NUM_CH));
   assign off_valid = (offset <= OFF_ISR);

   // One register block per channel plus its decoded strobes. A channel hit
   // can only occur for an in-range index, so strobes never fire for an
   // invalid channel.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_hit[i]   = (ch_field == ADDR_W'(i));
      assign cr_we[i]    = we & ch_hit[i] & (offset == OFF_CR);
      assign tx_write[i] = we & ch_hit[i] & (offset == OFF_TDR);
      assign ier_we[i]   = we & ch_hit[i] & (offset == OFF_IER);
      assign isr_we[i]   = we & ch_hit[i] & (offset == OFF_ISR);
      assign rx_read[i]  = re & ch_hit[i] & (offset == OFF_RDR);
      assign sr_read[i]  = re & ch_hit[i] & (offset == OFF_SR);

      uart_ch_regs #(
         .DATA_W (DATA_W),
         .IRQ_W  (IRQ_W)
      ) u_ch_regs (
         .clk        (clk),
         .rst_n      (rst_n),
         .cr_we      (cr_we[i]),
         .tdr_we     (tx_write[i]),
         .ier_we     (ier_we[i]),
         .isr_we     (isr_we[i]),
         .write_data (write_data),
         .irq_evt    (irq_evt[i*IRQ_W +: IRQ_W]),
         .cr         (cr[i*DATA_W +: DATA_W]),
         .tdr        (tdr[i*DATA_W +: DATA_W]),
         .ier        (ier_all[i]),
         .isr        (isr_all[i]),
         .irq        (irq[i])
      );
   end

   // Read multiplexer. It looks at the current register contents, so a read
   // coinciding with a write to the same register returns the old value.
   // Anything outside the mapped channel/offset space returns READ_DEFAULT.
   always_comb begin
      rd_mux = DATA_W'(READ_DEFAULT);
      if (ch_valid && off_valid) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
               case (offset)
                  OFF_CR:  rd_mux = cr[i*DATA_W +: DATA_W];
                  OFF_SR:  rd_mux = sr[i*DATA_W +: DATA_W];
                  OFF_TDR: rd_mux = tdr[i*DATA_W +: DATA_W];
                  OFF_RDR: rd_mux = rdr[i*DATA_W +: DATA_W];
                  OFF_IER: rd_mux = ier_all[i];
                  OFF_ISR: rd_mux = isr_all[i];
                  default: rd_mux = DATA_W'(READ_DEFAULT);
               endcase
            end
         end
      end
   end

   // Read data only changes on a read so the host can sample it late;
   // rvalid simply follows re by one cycle.
   always_comb begin
      read_data_d = read_data_q;
      if (re) begin
         read_data_d = rd_mux;
      end
      rvalid_d = re;
   end

   // Read response registers; reset drops any pending rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_q <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         read_data_q <= read_data_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign read_data = read_data_q;
   assign rvalid    = rvalid_q;

endmodule

// File: tb/tb_uart_multi_regs.sv
// ----------------------------------------------------------------------------
// tb_uart_multi_regs
//
// Self-checking bench for uart_multi_regs built with three channels so that
// ADDR_W = 5 and channel index 3 is an addressable but invalid channel.
// Address of a register = channel*8 + offset.
// ----------------------------------------------------------------------------
module tb_uart_multi_regs;

   localparam int NUM_CH = 3;
   localparam int DATA_W = 32;
   localparam int IRQ_W  = 8;
   localparam int ADDR_W = 5;

   logic                     clk;
   logic                     rst_n;
   logic [ADDR_W-1:0]        addr;
   logic                     we;
   logic                     re;
   logic [DATA_W-1:0]        write_data;
   logic [DATA_W-1:0]        read_data;
   logic                     rvalid;
   logic [NUM_CH*DATA_W-1:0] sr;
   logic [NUM_CH*DATA_W-1:0] rdr;
   logic [NUM_CH*IRQ_W-1:0]  irq_evt;
   logic [NUM_CH*DATA_W-1:0] cr;
   logic [NUM_CH*DATA_W-1:0] tdr;
   logic [NUM_CH-1:0]        tx_write;
   logic [NUM_CH-1:0]        rx_read;
   logic [NUM_CH-1:0]        sr_read;
   logic [NUM_CH-1:0]        irq;

   int total;
   int bad;

   typedef struct {
      string       name;
      logic        we;
      logic        re;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  exp_tx;
      logic [2:0]  exp_rx;
      logic [2:0]  exp_sr;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   uart_multi_regs #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .IRQ_W  (IRQ_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .we         (we),
      .re         (re),
      .write_data (write_data),
      .read_data  (read_data),
      .rvalid     (rvalid),
      .sr         (sr),
      .rdr        (rdr),
      .irq_evt    (irq_evt),
      .cr         (cr),
      .tdr        (tdr),
      .tx_write   (tx_write),
      .rx_read    (rx_read),
      .sr_read    (sr_read),
      .irq        (irq)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one bus cycle from the falling edge and let combinational strobes
   // settle; registered results of the previous cycle are also stable here.
   task automatic applyStimulus(input logic w, input logic r, input logic [4:0] a,
                                input logic [31:0] d, input logic [7:0] evt0);
      @(negedge clk);
      we         = w;
      re         = r;
      addr       = a;
      write_data = d;
      irq_evt    = {16'h0, evt0};
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 8'h00);
   endtask

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic addVec(input string n, input logic w, input logic r, input logic [4:0] a,
                         input logic [31:0] d, input logic [2:0] tx, input logic [2:0] rx,
                         input logic [2:0] s, input logic [31:0] rd);
      vec_t v;
      v.name = n; v.we = w; v.re = r; v.addr = a; v.wdata = d;
      v.exp_tx = tx; v.exp_rx = rx; v.exp_sr = s; v.exp_rd = rd;
      vecs.push_back(v);
   endtask

   initial begin
      vec_t v;
      total = 0;
      bad   = 0;

      rst_n      = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
      addr       = '0;
      write_data = '0;
      irq_evt    = '0;
      sr         = {32'h5A00_0002, 32'h5A00_0001, 32'h5A00_0000};
      rdr        = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};

      // name, we, re, addr, wdata, exp tx_write, rx_read, sr_read, read value
      addVec("cr0_rst",    0, 1, 5'd0,  32'h0,        3'b000, 3'b000, 3'b000, 32'h0000_C000);
      addVec("cr1_rst",    0, 1, 5'd8,  32'h0,        3'b000, 3'b000, 3'b000, 32'h0000_C000);
      addVec("tdr0_rst",   0, 1, 5'd2,  32'h0,        3'b000, 3'b000, 3'b000, 32'h0);
      addVec("tdr1_wr",    1, 0, 5'd10, 32'hA5,       3'b010, 3'b000, 3'b000, 32'h0);
      addVec("tdr1_rd",    0, 1, 5'd10, 32'h0,        3'b000, 3'b000, 3'b000, 32'hA5);
      addVec("tdr0_rd",    0, 1, 5'd2,  32'h0,        3'b000, 3'b000, 3'b000, 32'h0);
      addVec("sr2_rd",     0, 1, 5'd17, 32'h0,        3'b000, 3'b000, 3'b100, 32'h5A00_0002);
      addVec("rdr1_rd",    0, 1, 5'd11, 32'h0,        3'b000, 3'b010, 3'b000, 32'hC1);
      addVec("sr0_wr",     1, 0, 5'd1,  32'hFFFF,     3'b000, 3'b000, 3'b000, 32'h0);
      addVec("sr0_rd",     0, 1, 5'd1,  32'h0,        3'b000, 3'b000, 3'b001, 32'h5A00_0000);
      addVec("off6_rd",    0, 1, 5'd6,  32'h0,        3'b000, 3'b000, 3'b000, 32'hFFFF_0000);
      addVec("off7_rd",    0, 1, 5'd15, 32'h0,        3'b000, 3'b000, 3'b000, 32'hFFFF_0000);
      addVec("ch3_cr_rd",  0, 1, 5'd24, 32'h0,        3'b000, 3'b000, 3'b000, 32'hFFFF_0000);
      addVec("ch3_rdr_rd", 0, 1, 5'd27, 32'h0,        3'b000, 3'b000, 3'b000, 32'hFFFF_0000);
      addVec("ch3_sr_rd",  0, 1, 5'd25, 32'h0,        3'b000, 3'b000, 3'b000, 32'hFFFF_0000);
      addVec("ch3_tdr_wr", 1, 0, 5'd26, 32'h77,       3'b000, 3'b000, 3'b000, 32'h0);
      addVec("off6_wr",    1, 0, 5'd6,  32'h1234,     3'b000, 3'b000, 3'b000, 32'h0);
      addVec("tdr0_chk",   0, 1, 5'd2,  32'h0,        3'b000, 3'b000, 3'b000, 32'h0);
      addVec("tdr1_chk",   0, 1, 5'd10, 32'h0,        3'b000, 3'b000, 3'b000, 32'hA5);
      addVec("cr0_chk",    0, 1, 5'd0,  32'h0,        3'b000, 3'b000, 3'b000, 32'h0000_C000);
      addVec("ier2_wr",    1, 0, 5'd20, 32'hFFFF_FFFF, 3'b000, 3'b000, 3'b000, 32'h0);
      addVec("ier2_rd",    0, 1, 5'd20, 32'h0,        3'b000, 3'b000, 3'b000, 32'hFF);
      addVec("isr2_rd",    0, 1, 5'd21, 32'h0,        3'b000, 3'b000, 3'b000, 32'h0);
      addVec("ch3_ier_rd", 0, 1, 5'd28, 32'h0,        3'b000, 3'b000, 3'b000, 32'hFFFF_0000);

      // Reset state while rst_n is low
      #12;
      checkOutput("rst_read_data", 96'(read_data), 96'h0);
      checkOutput("rst_rvalid",    96'(rvalid),    96'h0);
      checkOutput("rst_irq",       96'(irq),       96'h0);
      checkOutput("rst_cr",        cr,  {32'h0000_C000, 32'h0000_C000, 32'h0000_C000});
      checkOutput("rst_tdr",       tdr, 96'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven single accesses, each followed by an idle cycle
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         applyStimulus(v.we, v.re, v.addr, v.wdata, 8'h00);
         checkOutput({v.name, "_tx"}, 96'(tx_write), 96'(v.exp_tx));
         checkOutput({v.name, "_rx"}, 96'(rx_read),  96'(v.exp_rx));
         checkOutput({v.name, "_sr"}, 96'(sr_read),  96'(v.exp_sr));
         idle();
         checkOutput({v.name, "_rvalid"}, 96'(rvalid), 96'(v.re));
         if (v.re) begin
            checkOutput({v.name, "_data"}, 96'(read_data), 96'(v.exp_rd));
         end
      end
      checkOutput("tdr_bus_after_tbl", tdr, {32'h0, 32'hA5, 32'h0});

      // CR reset bits: visible for one cycle, then self-clear
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h6, 8'h00);
      applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 8'h00);
      checkOutput("cr0_sc_port_t1", 96'(cr[31:0]), 96'h6);
      applyStimulus(1'b0, 1'b1, 5'd0, 32'h0, 8'h00);
      checkOutput("cr0_sc_read_t1", 96'(read_data), 96'h6);
      idle();
      checkOutput("cr0_sc_read_t2", 96'(read_data), 96'h0);
      checkOutput("cr0_sc_rvalid",  96'(rvalid),    96'h1);

      // A CR write in the clear cycle wins over the self-clear
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h6, 8'h00);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h4, 8'h00);
      idle();
      checkOutput("cr0_wr_wins",  96'(cr[31:0]), 96'h4);
      idle();
      checkOutput("cr0_wr_clear", 96'(cr[31:0]), 96'h0);

      // Simultaneous write and read: read returns the old value
      applyStimulus(1'b1, 1'b1, 5'd2, 32'h55, 8'h00);
      checkOutput("wr_rd_tx", 96'(tx_write), 96'b001);
      applyStimulus(1'b0, 1'b1, 5'd2, 32'h0, 8'h00);
      checkOutput("wr_rd_old", 96'(read_data), 96'h0);
      idle();
      checkOutput("wr_rd_new", 96'(read_data), 96'h55);

      // Interrupt set, W1C, and set-wins on a coincident clear
      applyStimulus(1'b1, 1'b0, 5'd4, 32'h1, 8'h00);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 8'h01);
      checkOutput("irq_before_evt", 96'(irq), 96'b000);
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h0, 8'h00);
      checkOutput("irq_after_evt", 96'(irq), 96'b001);
      idle();
      checkOutput("isr0_read", 96'(read_data), 96'h1);
      applyStimulus(1'b1, 1'b0, 5'd5, 32'h1, 8'h00);
      idle();
      checkOutput("irq_after_w1c", 96'(irq), 96'b000);
      applyStimulus(1'b1, 1'b0, 5'd5, 32'h1, 8'h01);
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h0, 8'h00);
      checkOutput("irq_set_wins", 96'(irq), 96'b001);
      idle();
      checkOutput("isr0_set_wins", 96'(read_data), 96'h1);
      applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, 8'h00);
      idle();
      checkOutput("irq_w0_noeffect", 96'(irq), 96'b001);

      // Four back-to-back RDR reads with a changing live value
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rdr[31:0]  = 32'hD0 + 32'(k);
         we         = 1'b0;
         re         = 1'b1;
         addr       = 5'd3;
         write_data = '0;
         irq_evt    = '0;
         #1;
         checkOutput($sformatf("b2b_rx_%0d", k), 96'(rx_read), 96'b001);
         if (k > 0) begin
            checkOutput($sformatf("b2b_rvalid_%0d", k), 96'(rvalid), 96'h1);
            checkOutput($sformatf("b2b_data_%0d", k), 96'(read_data), 96'(32'hD0 + 32'(k - 1)));
         end
      end
      idle();
      checkOutput("b2b_rvalid_4", 96'(rvalid),    96'h1);
      checkOutput("b2b_data_4",   96'(read_data), 96'hD3);
      checkOutput("b2b_rx_off",   96'(rx_read),   96'b000);
      idle();
      checkOutput("b2b_rvalid_end", 96'(rvalid),    96'h0);
      checkOutput("b2b_data_hold",  96'(read_data), 96'hD3);

      // Reset during operation with an rvalid about to appear
      applyStimulus(1'b0, 1'b1, 5'd8, 32'h0, 8'h00);
      @(negedge clk);
      re    = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_rvalid", 96'(rvalid),    96'h0);
      checkOutput("mid_rst_data",   96'(read_data), 96'h0);
      checkOutput("mid_rst_irq",    96'(irq),       96'h0);
      checkOutput("mid_rst_tdr",    tdr,            96'h0);
      checkOutput("mid_rst_cr",     cr,  {32'h0000_C000, 32'h0000_C000, 32'h0000_C000});
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h0, 8'h00);
      idle();
      checkOutput("post_rst_isr0", 96'(read_data), 96'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
